// File: rtl/abs_diff_sad_pipe_if.sv
// Operand/result stream bundle for abs_diff_sad_pipe: one valid/ready input
// stream of (a, b, last, mode) beats and one valid/ready result stream.
interface abs_diff_sad_pipe_if #(
   parameter int WIDTH = 4,
   parameter int ACC_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_last;
   logic             in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic             out_last;
   logic             out_ovf;

   // Master is the operand source and result sink; slave is the arithmetic block.
   modport master (
      output in_valid, in_a, in_b, in_last, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_last, out_ovf
   );
endinterface

// File: rtl/abs_diff_sad_pipe.sv
// Two-stage |a-b| pipeline: S1 holds the difference, S2 is the output register.
// Mode 0 emits every difference; mode 1 emits one saturating SAD per frame.
module abs_diff_sad_pipe #(
   parameter int WIDTH = 4,
   parameter int ACC_W = 12
) (
   input logic              clk,
   input logic              rst,
   abs_diff_sad_pipe_if.slave bus
);

   typedef enum logic {
      MODE_BEAT = 1'b0,
      MODE_SAD  = 1'b1
   } mode_e;

   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   // Frame control
   logic              r_frame_start;
   mode_e             r_mode;

   // Stage 1
   logic              r_s1_valid;
   logic [WIDTH-1:0]  r_s1_d;
   logic              r_s1_last;
   mode_e             r_s1_mode;

   // Accumulator
   logic [ACC_W-1:0]  r_acc;
   logic              r_ovf;

   // Stage 2 (output register)
   logic              r_out_valid;
   logic [ACC_W-1:0]  r_out_data;
   logic              r_out_last;
   logic              r_out_ovf;

   logic              w_advance;
   logic              w_accept;
   mode_e             w_mode_eff;
   logic [WIDTH-1:0]  w_diff;
   logic [ACC_W:0]    w_sum;
   logic              w_sat;
   logic [ACC_W-1:0]  w_sum_clamped;

   // NOTE: in_ready depends only on registered state and out_ready, never on
   // in_valid, so upstream may legally wait for ready before raising valid.
   always_comb begin
      w_advance     = !r_out_valid || bus.out_ready;
      w_accept      = bus.in_valid && w_advance;
      w_mode_eff    = r_frame_start ? mode_e'(bus.in_mode) : r_mode;
      w_diff        = (bus.in_a >= bus.in_b) ? (bus.in_a - bus.in_b)
                                             : (bus.in_b - bus.in_a);
      w_sum         = {1'b0, r_acc} + (ACC_W+1)'(r_s1_d);
      w_sat         = w_sum[ACC_W];
      w_sum_clamped = w_sat ? ACC_MAX : w_sum[ACC_W-1:0];
   end

   assign bus.in_ready  = w_advance;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.out_ovf   = r_out_ovf;

   // NOTE: all state is updated with non-blocking assignments so every stage
   // samples the pre-edge values of the stage before it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_start <= 1'b1;
         r_mode        <= MODE_BEAT;
         r_s1_valid    <= 1'b0;
         r_s1_d        <= '0;
         r_s1_last     <= 1'b0;
         r_s1_mode     <= MODE_BEAT;
         r_acc         <= '0;
         r_ovf         <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_last    <= 1'b0;
         r_out_ovf     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_frame_start <= bus.in_last;
            if (r_frame_start) r_mode <= mode_e'(bus.in_mode);
         end

         if (w_advance) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
               r_s1_d    <= w_diff;
               r_s1_last <= bus.in_last;
               r_s1_mode <= w_mode_eff;
            end

            // S2 empties unless the beat leaving S1 produces a result.
            r_out_valid <= 1'b0;
            if (r_s1_valid) begin
               if (r_s1_mode == MODE_BEAT) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= ACC_W'(r_s1_d);
                  r_out_last  <= r_s1_last;
                  r_out_ovf   <= 1'b0;
               end else if (r_s1_last) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_sum_clamped;
                  r_out_last  <= 1'b1;
                  r_out_ovf   <= r_ovf | w_sat;
                  r_acc       <= '0;
                  r_ovf       <= 1'b0;
               end else begin
                  r_acc <= w_sum_clamped;
                  r_ovf <= r_ovf | w_sat;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_abs_diff_sad_pipe.sv
// Self-checking bench: two instances (ACC_W=12 and ACC_W=5) share one stimulus
// stream and are compared against a frame-level reference model.
module tb_abs_diff_sad_pipe;

   localparam int W     = 4;
   localparam int AW_A  = 12;
   localparam int AW_B  = 5;
   localparam int MAX_A = (1 << AW_A) - 1;
   localparam int MAX_B = (1 << AW_B) - 1;

   typedef struct {
      int data;
      bit last;
      bit ovf;
      int cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         v = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         last = 1'b0;
   logic         mode = 1'b0;
   logic         ordy = 1'b1;

   always #5 clk = ~clk;

   abs_diff_sad_pipe_if #(.WIDTH(W), .ACC_W(AW_A)) ia ();
   abs_diff_sad_pipe_if #(.WIDTH(W), .ACC_W(AW_B)) ib ();

   assign ia.in_valid = v;    assign ib.in_valid = v;
   assign ia.in_a = a;        assign ib.in_a = a;
   assign ia.in_b = b;        assign ib.in_b = b;
   assign ia.in_last = last;  assign ib.in_last = last;
   assign ia.in_mode = mode;  assign ib.in_mode = mode;
   assign ia.out_ready = ordy; assign ib.out_ready = ordy;

   abs_diff_sad_pipe #(.WIDTH(W), .ACC_W(AW_A)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   abs_diff_sad_pipe #(.WIDTH(W), .ACC_W(AW_B)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   int   total = 0;
   int   bad = 0;
   int   cyc_n = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   // Reference model state
   bit m_start = 1'b1;
   bit m_mode = 1'b0;
   int acc_a = 0, acc_b = 0;
   bit ovf_a = 1'b0, ovf_b = 1'b0;

   bit lat_chk = 1'b0;
   bit bp_en = 1'b0;
   int bp_cnt = 0;
   bit stall_prev = 1'b0;
   logic [AW_A-1:0] prev_data = '0;

   int got_a_data = 0, got_b_data = 0;
   bit got_a_last = 1'b0, got_a_ovf = 1'b0, got_b_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_accept(input int x, input int y, input bit l, input bit md);
      int d;
      d = (x >= y) ? x - y : y - x;
      if (m_start) m_mode = md;
      if (!m_mode) begin
         q_a.push_back('{d, l, 1'b0, cyc_n});
         q_b.push_back('{d, l, 1'b0, cyc_n});
      end else begin
         acc_a += d;
         acc_b += d;
         if (acc_a > MAX_A) begin acc_a = MAX_A; ovf_a = 1'b1; end
         if (acc_b > MAX_B) begin acc_b = MAX_B; ovf_b = 1'b1; end
         if (l) begin
            q_a.push_back('{acc_a, 1'b1, ovf_a, cyc_n});
            q_b.push_back('{acc_b, 1'b1, ovf_b, cyc_n});
            acc_a = 0; acc_b = 0; ovf_a = 1'b0; ovf_b = 1'b0;
         end
      end
      m_start = l;
   endtask

   // One clock: sample and check at the falling edge, then return 1 time unit
   // after the rising edge, which is where inputs are driven.
   task automatic cycle(output bit acc);
      exp_t e;
      @(negedge clk);
      check("ready_a", 32'(ia.in_ready), 32'(!ia.out_valid || ordy));
      check("ready_b", 32'(ib.in_ready), 32'(!ib.out_valid || ordy));
      if (stall_prev) begin
         check("hold_valid", 32'(ia.out_valid), 32'd1);
         check("hold_data", 32'(ia.out_data), 32'(prev_data));
      end
      if (ia.out_valid && ordy) begin
         if (q_a.size() == 0) check("spurious_a", 32'(ia.out_valid), 32'd0);
         else begin
            e = q_a.pop_front();
            check("data_a", 32'(ia.out_data), 32'(e.data));
            check("last_a", 32'(ia.out_last), 32'(e.last));
            check("ovf_a", 32'(ia.out_ovf), 32'(e.ovf));
            if (lat_chk) check("latency", 32'(cyc_n - e.cyc), 32'd2);
            got_a_data = int'(ia.out_data);
            got_a_last = ia.out_last;
            got_a_ovf  = ia.out_ovf;
         end
      end
      if (ib.out_valid && ordy) begin
         if (q_b.size() == 0) check("spurious_b", 32'(ib.out_valid), 32'd0);
         else begin
            e = q_b.pop_front();
            check("data_b", 32'(ib.out_data), 32'(e.data));
            check("last_b", 32'(ib.out_last), 32'(e.last));
            check("ovf_b", 32'(ib.out_ovf), 32'(e.ovf));
            got_b_data = int'(ib.out_data);
            got_b_ovf  = ib.out_ovf;
         end
      end
      acc = v && ia.in_ready;
      if (acc) model_accept(int'(a), int'(b), last, mode);
      stall_prev = ia.out_valid && !ordy;
      prev_data  = ia.out_data;
      cyc_n++;
      @(posedge clk);
      #1;
      if (bp_en) begin
         ordy = (bp_cnt % 3 == 0);
         bp_cnt++;
      end
   endtask

   task automatic send(input int x, input int y, input bit l, input bit md);
      bit acc;
      int n;
      n = 0;
      v = 1'b1; a = W'(x); b = W'(y); last = l; mode = md;
      do begin
         cycle(acc);
         n++;
      end while (!acc && n < 64);
      if (!acc) check("accept_timeout", 32'(acc), 32'd1);
      v = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      v = 1'b0;
      repeat (n) cycle(acc);
   endtask

   // Asynchronous reset asserted away from any clock edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_valid_a", 32'(ia.out_valid), 32'd0);
      check("rst_data_a", 32'(ia.out_data), 32'd0);
      check("rst_last_a", 32'(ia.out_last), 32'd0);
      check("rst_ovf_a", 32'(ia.out_ovf), 32'd0);
      check("rst_valid_b", 32'(ib.out_valid), 32'd0);
      q_a.delete(); q_b.delete();
      m_start = 1'b1; m_mode = 1'b0;
      acc_a = 0; acc_b = 0; ovf_a = 1'b0; ovf_b = 1'b0;
      stall_prev = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_post_rst", 32'(ia.in_ready), 32'd1);
   endtask

   initial begin
      bit acc;
      #1 rst = 1'b1;
      #2;
      check("rst_valid_a", 32'(ia.out_valid), 32'd0);
      check("rst_data_a", 32'(ia.out_data), 32'd0);
      check("rst_last_a", 32'(ia.out_last), 32'd0);
      check("rst_ovf_a", 32'(ia.out_ovf), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_post_rst", 32'(ia.in_ready), 32'd1);

      // Mode 0 stream, latency checked
      lat_chk = 1'b1;
      send(3, 9, 1'b0, 1'b0);
      send(9, 3, 1'b0, 1'b0);
      send(15, 0, 1'b0, 1'b0);
      send(7, 7, 1'b1, 1'b0);
      idle(3);
      check("m0_final", 32'(got_a_data), 32'd0);

      // Mode 1 frame; the mid-frame in_mode=0 must be ignored
      send(1, 5, 1'b0, 1'b1);
      send(10, 2, 1'b0, 1'b0);
      send(4, 4, 1'b0, 1'b1);
      send(0, 15, 1'b1, 1'b1);
      idle(3);
      check("sad27", 32'(got_a_data), 32'd27);
      check("sad27_last", 32'(got_a_last), 32'd1);
      check("sad27_ovf", 32'(got_a_ovf), 32'd0);
      send(2, 1, 1'b1, 1'b1);
      idle(3);
      check("fresh_acc", 32'(got_a_data), 32'd1);

      // Saturation in the 5-bit accumulator
      send(15, 0, 1'b0, 1'b1);
      send(15, 0, 1'b0, 1'b1);
      send(15, 0, 1'b1, 1'b1);
      idle(3);
      check("sat_b", 32'(got_b_data), 32'd31);
      check("sat_b_ovf", 32'(got_b_ovf), 32'd1);
      check("nosat_a", 32'(got_a_data), 32'd45);
      send(2, 1, 1'b1, 1'b1);
      idle(3);
      check("after_sat_b", 32'(got_b_data), 32'd1);
      check("after_sat_ovf", 32'(got_b_ovf), 32'd0);

      // Back-to-back mode switch
      send(2, 0, 1'b0, 1'b1);
      send(0, 3, 1'b1, 1'b0);
      send(5, 1, 1'b0, 1'b0);
      idle(3);
      check("switch_m0", 32'(got_a_data), 32'd4);
      check("switch_m0_last", 32'(got_a_last), 32'd0);
      send(4, 4, 1'b1, 1'b0);
      idle(3);
      lat_chk = 1'b0;

      // Backpressure with out_ready pattern 1,0,0,...
      bp_cnt = 0;
      bp_en = 1'b1;
      for (int i = 0; i < 6; i++) send(2 * i + 1, 12 - i, i == 5, 1'b0);
      idle(6);
      bp_en = 1'b0;
      ordy = 1'b1;
      idle(4);

      // Reset while an output is held by backpressure
      ordy = 1'b0;
      send(9, 2, 1'b1, 1'b0);
      idle(3);
      check("held_before_rst", 32'(ia.out_valid), 32'd1);
      do_reset();
      ordy = 1'b1;

      // Reset in the middle of a mode 1 frame discards the partial sum
      send(1, 0, 1'b0, 1'b1);
      send(2, 0, 1'b0, 1'b1);
      do_reset();
      lat_chk = 1'b1;
      send(1, 0, 1'b1, 1'b1);
      idle(3);
      check("post_rst_frame", 32'(got_a_data), 32'd1);
      lat_chk = 1'b0;

      // Random traffic with random idles, frame ends, modes and backpressure
      for (int i = 0; i < 600; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         a    = W'($urandom);
         b    = W'($urandom);
         last = ($urandom_range(0, 3) == 0);
         mode = 1'($urandom);
         ordy = ($urandom_range(0, 3) != 0);
         cycle(acc);
      end
      v = 1'b0;
      ordy = 1'b1;
      idle(6);
      check("drain_a", 32'(q_a.size()), 32'd0);
      check("drain_b", 32'(q_b.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
